axis_fifo_rr_arb: RTL
=====================

// Module: axis_fifo_rr_arb
// PURPOSE
//  Round-robin scheduler draining NCH axis_fifo output streams onto one shared AXI-stream.
//  Grants one channel per burst of up to BURST beats and tags every beat with its source id.
//  Sits between per-channel axis_fifo instances and a single downstream consumer (DMA/framer).
// PARAMETERS
//  NCH        4   number of input channels (2..8)
//  CH_BITS    2   width of channel id, >= clog2(NCH)
//  WIDTH      32  data width per channel
//  USED_BITS  6   width of each s_used field (matches axis_fifo fifo_used)
//  BURST      16  max beats per grant (2..256)
//  HIGH_WM    48  fill threshold for urgent priority (only with AXIS_ARB_FILL_PRIO_EN)
// PORTS
//  clk        in   1                clock
//  rst_n      in   1                asynchronous reset, active low
//  s_tdata    in   NCH*WIDTH        channel data, ch i at [i*WIDTH +: WIDTH]
//  s_tvalid   in   NCH              channel valid
//  s_tready   out  NCH              channel ready, at most one bit set
//  s_used     in   NCH*USED_BITS    channel fifo_used, ch i at [i*USED_BITS +: USED_BITS]
//  m_tdata    out  WIDTH            output data (registered)
//  m_tvalid   out  1                output valid (registered)
//  m_tready   in   1                output ready
//  m_tid      out  CH_BITS          source channel of current m_tdata beat
//  m_tlast    out  1                beat ends a burst that hit the BURST limit
//  busy       out  1                FSM in S_BURST
// BEHAVIOUR
//  - Reset (async assert, sync release): state S_IDLE, ptr=NCH-1, cnt=0; m_tvalid, m_tdata,
//    m_tid, m_tlast, busy, s_tready all 0. Reset mid-burst drops the in-flight output beat.
//  - Output register: load = ~m_tvalid | m_tready. On load with an accepted input beat:
//    m_tdata/m_tid/m_tlast update and m_tvalid=1; on load without a beat: m_tvalid=0.
//    Data latency 1 cycle input-accept to m_tvalid.
//  - S_IDLE: if |s_tvalid, pick = first valid channel searching ptr+1, ptr+2, ... (mod NCH);
//    grant<=pick, ptr<=pick, cnt<=0, -> S_BURST. s_tready all 0 in S_IDLE (1 bubble per grant).
//  - S_BURST: s_tready[grant] = load & s_tvalid-independent; beat accepted = s_tvalid[grant] &
//    s_tready[grant]. Each beat cnt++.
//    * beat with cnt==BURST-1: m_tlast=1 on that beat, -> S_IDLE.
//    * s_tvalid[grant]==0 while load==1: grant ends, -> S_IDLE, no tlast (starved burst).
//    * load==0 (downstream stall): hold state, cnt and grant; no early termination.
//  - Fairness: ptr advances only on grant; a channel valid continuously is served within
//    NCH-1 other grants. Single valid channel gets back-to-back bursts with 1 bubble each.
//  - cnt width clog2(BURST)+1, never wraps (reset to 0 at each grant).
//  - s_tready never asserted for more than one channel, never for a non-granted channel.
// CONFIGURATION
//  AXIS_ARB_FILL_PRIO_EN defined: in S_IDLE, urgent = s_tvalid[i] & (s_used[i] >= HIGH_WM);
//    if any urgent, round-robin pick (from ptr+1) among urgent only; else among all valid.
//  Not defined: s_used ignored (port kept, unconnected internally), pure round-robin.
// TESTING
//  1 reset, ch0..3 all valid, m_tready=1 -> grants 0,1,2,3,0; 16 beats each, m_tid matches,
//    m_tlast on 16th beat of each, one idle cycle between bursts.
//  2 only ch2 valid, 5 beats then tvalid low -> 5 beats m_tid=2, no m_tlast, FSM back to S_IDLE.
//  3 ch1 streaming, m_tready low 10 cycles mid-burst -> m_tdata held stable, no s_tready,
//    cnt unchanged, burst resumes and completes 16 beats total.
//  4 rst_n pulsed low mid-burst -> m_tvalid=0 immediately; after release first grant is ch0
//    if valid.
//  5 FILL_PRIO_EN, ptr=0, ch1 and ch3 valid, s_used[3]=50, s_used[1]=10 -> ch3 granted first;
//    without macro -> ch1 first.
//  6 random valid/ready on all channels, 10k cycles -> per-channel data order preserved,
//    no beat lost/duplicated, onehot-or-zero s_tready every cycle.

Source files
------------

// File: rtl/axis_fifo_rr_arb.sv
// axis_fifo_rr_arb: round-robin burst scheduler that drains NCH AXI-stream
// channels onto one registered output stream, tagging each beat with its
// source channel id.
// Optional feature macro: AXIS_ARB_FILL_PRIO_EN -- when defined, channels whose
// s_used >= HIGH_WM are preferred at grant time; otherwise s_used is ignored.
module axis_fifo_rr_arb #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned CH_BITS   = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned USED_BITS = 6,
  parameter int unsigned BURST     = 16,
  parameter int unsigned HIGH_WM   = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH*WIDTH-1:0]     s_tdata,
  input  logic [NCH-1:0]           s_tvalid,
  output logic [NCH-1:0]           s_tready,
  input  logic [NCH*USED_BITS-1:0] s_used,
  output logic [WIDTH-1:0]         m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [CH_BITS-1:0]       m_tid,
  output logic                     m_tlast,
  output logic                     busy
);

  localparam int unsigned          CNT_W    = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [CH_BITS-1:0]   PTR_RST  = CH_BITS'(NCH - 1);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e             state_q, state_d;
  logic [CH_BITS-1:0] grant_q, grant_d;
  logic [CH_BITS-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [CH_BITS-1:0] m_tid_q, m_tid_d;
  logic               m_tlast_q, m_tlast_d;

  logic               load;
  logic               beat;
  logic               sel_valid;
  logic [WIDTH-1:0]   sel_data;
  logic [NCH-1:0]     cand;
  logic [CH_BITS-1:0] pick;
  logic               pick_ok;

  assign load = ~m_tvalid_q | m_tready;

`ifdef AXIS_ARB_FILL_PRIO_EN
  logic [NCH-1:0] urgent;

  // Candidate set: urgent (nearly full) channels if any, otherwise all valid ones.
  always_comb begin
    urgent = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      urgent[i] = s_tvalid[i] && (32'(s_used[i*USED_BITS +: USED_BITS]) >= HIGH_WM);
    end
    cand = (|urgent) ? urgent : s_tvalid;
  end
`else
  logic unused_used;
  assign unused_used = ^{s_used, HIGH_WM[0]};
  assign cand        = s_tvalid;
`endif

  // Round-robin pick: first candidate searching ptr+1, ptr+2, ... modulo NCH.
  always_comb begin
    pick    = ptr_q;
    pick_ok = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      for (int unsigned j = 0; j < NCH; j++) begin
        if (!pick_ok && cand[j] && (j == ((32'(ptr_q) + k) % NCH))) begin
          pick    = CH_BITS'(j);
          pick_ok = 1'b1;
        end
      end
    end
  end

  // Mux the granted channel's valid and data.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (grant_q == CH_BITS'(j)) begin
        sel_valid = s_tvalid[j];
        sel_data  = s_tdata[j*WIDTH +: WIDTH];
      end
    end
  end

  // FSM state register plus grant bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant on any valid in idle; leave burst on last beat or starvation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          grant_d = pick;
          ptr_d   = pick;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        // A downstream stall (load low) freezes everything; only a free output
        // slot can end the grant, either on the final beat or on a missing beat.
        if (load) begin
          if (sel_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready only to the granted channel while the output slot is free.
  always_comb begin
    s_tready = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if ((state_q == S_BURST) && (grant_q == CH_BITS'(j))) s_tready[j] = load;
    end
    busy = (state_q == S_BURST);
    beat = (state_q == S_BURST) && load && sel_valid;
  end

  // Output register next value: load a beat, or empty the slot when nothing arrives.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tid_d    = m_tid_q;
    m_tlast_d  = m_tlast_q;
    if (load) begin
      m_tvalid_d = beat;
      if (beat) begin
        m_tdata_d = sel_data;
        m_tid_d   = grant_q;
        m_tlast_d = (cnt_q == CNT_LAST);
      end
    end
  end

  // Output register; reset drops any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tid_q    <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tid_q    <= m_tid_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tid    = m_tid_q;
  assign m_tlast  = m_tlast_q;

endmodule
